// File: rtl/display_buf.sv
// Display output buffer: CPU-written 7-bit characters are queued in a FIFO and
// drained one at a time to a UART transmitter over a start/done handshake.
// Optional LF -> CR,LF expansion is enabled by defining DISPLAY_BUF_CRLF_EXPAND_EN.
module display_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DSP_write_en,
  input  logic [6:0] DSP_data,
  input  logic       DSP_clear,
  output logic       DSP_status,
  output logic       buf_full,
  output logic       buf_empty,
  output logic       overflow,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_done
);

  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [6:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              state;
  logic [6:0]        head;
  logic              wr_accept;
  logic              send;
  logic              pop;
  logic [7:0]        send_byte;

`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
  logic crlf_pending;
  logic expand;
`endif

  assign buf_full   = (count == FULL_COUNT);
  assign buf_empty  = (count == '0);
  assign DSP_status = !buf_full;
  assign head       = mem[rd_ptr];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_accept = DSP_write_en && !buf_full;
    send      = (state == IDLE) && !buf_empty && !tx_busy;
    pop       = send;
    send_byte = {1'b0, head};
`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
    expand = (head == 7'h0A) && !crlf_pending;
    if (expand) begin
      pop       = 1'b0;
      send_byte = 8'h0D;
    end
`endif
  end

  // NOTE: the character storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && !DSP_clear && wr_accept) begin
      mem[wr_ptr] <= DSP_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      tx_start <= 1'b0;
      overflow <= 1'b0;
      tx_data  <= '0;
`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
      crlf_pending <= 1'b0;
`endif
    end else if (DSP_clear) begin
      // tx_data deliberately keeps the last byte handed to the transmitter
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      tx_start <= 1'b0;
      overflow <= 1'b0;
`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
      crlf_pending <= 1'b0;
`endif
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end else if (DSP_write_en) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end

      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (send) begin
            tx_data  <= send_byte;
            tx_start <= 1'b1;
            state    <= WAIT;
`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
            crlf_pending <= expand;
`endif
          end else begin
            tx_start <= 1'b0;
          end
        end
        default: begin
          tx_start <= 1'b0;
          if (tx_done) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_buf.sv
// Directed self-checking bench for display_buf with a transmitter model that
// answers each tx_start with a one-cycle tx_done ten cycles later.
module tb_display_buf;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic       clk;
  logic       reset;
  logic       DSP_write_en;
  logic [6:0] DSP_data;
  logic       DSP_clear;
  logic       DSP_status;
  logic       buf_full;
  logic       buf_empty;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;

  logic       force_busy;
  logic       model_busy;
  logic [7:0] sent_q[$];
  int         tests_run;
  int         tests_failed;
  int         base;

  display_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .DSP_write_en (DSP_write_en),
    .DSP_data     (DSP_data),
    .DSP_clear    (DSP_clear),
    .DSP_status   (DSP_status),
    .buf_full     (buf_full),
    .buf_empty    (buf_empty),
    .overflow     (overflow),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  assign tx_busy = force_busy | model_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with tx_start high is one byte handed to the transmitter.
  always @(posedge clk) begin
    #1;
    if (tx_start === 1'b1) sent_q.push_back(tx_data);
  end

  // Transmitter model: busy for ten cycles, then a one-cycle tx_done.
  initial begin
    model_busy = 1'b0;
    tx_done    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1) begin
        model_busy = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        tx_done    = 1'b1;
        model_busy = 1'b0;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [6:0] c);
    DSP_write_en = 1'b1;
    DSP_data     = c;
    tick();
    DSP_write_en = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget, input string tag);
    int cycles = 0;
    while (sent_q.size() < n && cycles < budget) begin
      tick();
      cycles++;
    end
    check(tag, 32'(sent_q.size() >= n), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    DSP_write_en = 1'b0;
    DSP_data     = '0;
    DSP_clear    = 1'b0;
    force_busy   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_status", 32'(DSP_status), 32'd1);
    check("rst_empty",  32'(buf_empty),  32'd1);
    check("rst_full",   32'(buf_full),   32'd0);
    check("rst_ovf",    32'(overflow),   32'd0);
    check("rst_start",  32'(tx_start),   32'd0);
    check("rst_data",   32'(tx_data),    32'h00);
    reset = 1'b0;
    tick();

    // Single character latency: write at edge N, start pulse N+1..N+2
    base = sent_q.size();
    write_char(7'h68);
    check("lat_start_n",   32'(tx_start),  32'd0);
    check("lat_empty_n",   32'(buf_empty), 32'd0);
    tick();
    check("lat_start_n1",  32'(tx_start),  32'd1);
    check("lat_data_n1",   32'(tx_data),   32'h68);
    check("lat_empty_n1",  32'(buf_empty), 32'd1);
    tick();
    check("lat_start_n2",  32'(tx_start),  32'd0);
    repeat (15) tick();
    check("lat_count",     32'(sent_q.size() - base), 32'd1);

    // "hello" back to back
    base = sent_q.size();
    write_char(7'h68);
    write_char(7'h65);
    write_char(7'h6C);
    write_char(7'h6C);
    write_char(7'h6F);
    wait_sent(base + 5, 200, "hello_wait");
    repeat (20) tick();
    check("hello_count", 32'(sent_q.size() - base), 32'd5);
    check("hello_b0", 32'(sent_q[base + 0]), 32'h68);
    check("hello_b1", 32'(sent_q[base + 1]), 32'h65);
    check("hello_b2", 32'(sent_q[base + 2]), 32'h6C);
    check("hello_b3", 32'(sent_q[base + 3]), 32'h6C);
    check("hello_b4", 32'(sent_q[base + 4]), 32'h6F);
    check("hello_ovf", 32'(overflow), 32'd0);

    // Fill while the transmitter is busy, then overrun by two
    base = sent_q.size();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      write_char(7'(8'h30 + i));
      if (i == DEPTH - 2) check("fill_notfull", 32'(buf_full), 32'd0);
      if (i == DEPTH - 1) begin
        check("fill_full",   32'(buf_full),   32'd1);
        check("fill_status", 32'(DSP_status), 32'd0);
        check("fill_ovf0",   32'(overflow),   32'd0);
      end
    end
    check("fill_ovf1", 32'(overflow), 32'd1);
    check("fill_nostart", 32'(sent_q.size() - base), 32'd0);
    force_busy = 1'b0;
    wait_sent(base + DEPTH, 400, "fill_wait");
    repeat (20) tick();
    check("fill_count", 32'(sent_q.size() - base), 32'(DEPTH));
    check("fill_first",  32'(sent_q[base]),             32'h30);
    check("fill_second", 32'(sent_q[base + 1]),         32'h31);
    check("fill_last",   32'(sent_q[base + DEPTH - 1]), 32'h3F);
    check("fill_empty",  32'(buf_empty), 32'd1);
    check("fill_sticky", 32'(overflow),  32'd1);

    // Full FIFO: write and pop in the same cycle
    DSP_clear = 1'b1;
    tick();
    DSP_clear = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    base = sent_q.size();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_char(7'(8'h40 + i));
    check("wp_full", 32'(buf_full), 32'd1);
    force_busy   = 1'b0;
    DSP_write_en = 1'b1;
    DSP_data     = 7'h7E;
    tick();
    DSP_write_en = 1'b0;
    force_busy   = 1'b1;
    check("wp_start", 32'(tx_start), 32'd1);
    check("wp_data",  32'(tx_data),  32'h40);
    check("wp_ovf",   32'(overflow), 32'd1);
    check("wp_notfull", 32'(buf_full), 32'd0);
    write_char(7'h7D);
    check("wp_refull", 32'(buf_full), 32'd1);
    force_busy = 1'b0;
    wait_sent(base + DEPTH + 1, 450, "wp_wait");
    repeat (20) tick();
    check("wp_count", 32'(sent_q.size() - base), 32'(DEPTH + 1));
    check("wp_b15",   32'(sent_q[base + DEPTH - 1]), 32'h4F);
    check("wp_b16",   32'(sent_q[base + DEPTH]),     32'h7D);

    // Clear during WAIT with three characters queued
    base = sent_q.size();
    write_char(7'h50);
    write_char(7'h51);
    write_char(7'h52);
    write_char(7'h53);
    check("cw_inflight", 32'(sent_q.size() - base), 32'd1);
    check("cw_notempty", 32'(buf_empty), 32'd0);
    DSP_clear  = 1'b1;
    force_busy = 1'b1;
    tick();
    DSP_clear = 1'b0;
    check("cw_empty",  32'(buf_empty),  32'd1);
    check("cw_status", 32'(DSP_status), 32'd1);
    check("cw_ovf",    32'(overflow),   32'd0);
    check("cw_hold",   32'(tx_data),    32'h50);
    repeat (30) tick();
    check("cw_nostart", 32'(sent_q.size() - base), 32'd1);
    force_busy = 1'b0;
    tick();
    write_char(7'h41);
    wait_sent(base + 2, 50, "cw_wait");
    repeat (15) tick();
    check("cw_count", 32'(sent_q.size() - base), 32'd2);
    check("cw_new",   32'(sent_q[base + 1]),     32'h41);

    // Line feed handling
    base = sent_q.size();
    write_char(7'h61);
    write_char(7'h0A);
`ifdef DISPLAY_BUF_CRLF_EXPAND_EN
    wait_sent(base + 3, 100, "lf_wait");
    repeat (20) tick();
    check("lf_count", 32'(sent_q.size() - base), 32'd3);
    check("lf_b0", 32'(sent_q[base + 0]), 32'h61);
    check("lf_b1", 32'(sent_q[base + 1]), 32'h0D);
    check("lf_b2", 32'(sent_q[base + 2]), 32'h0A);
`else
    wait_sent(base + 2, 100, "lf_wait");
    repeat (20) tick();
    check("lf_count", 32'(sent_q.size() - base), 32'd2);
    check("lf_b0", 32'(sent_q[base + 0]), 32'h61);
    check("lf_b1", 32'(sent_q[base + 1]), 32'h0A);
`endif
    check("lf_empty", 32'(buf_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/display_buf.md
Name: display_buf

Overview:
- Output-side counterpart of the keyboard buffer in the Y86 memory-mapped console.
- The CPU writes 7-bit ASCII characters into a FIFO. The block drains that FIFO one character at a time into the UART transmitter, using a start/done handshake.
- Exposes a status bit the CPU polls before writing, plus full, empty and overflow flags.

Parameters:
- DEPTH, 16, FIFO depth in characters; must be a power of 2, minimum 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- DSP_write_en  in  1  CPU write strobe; one character per cycle it is high.
- DSP_data  in  7  ASCII character from the CPU.
- DSP_clear  in  1  synchronous flush of FIFO, FSM and flags.
- DSP_status  out  1  1 = space available (count < DEPTH).
- buf_full  out  1  count == DEPTH.
- buf_empty  out  1  count == 0.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- tx_data  out  8  byte to transmitter, formed as {1'b0, char}.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_busy  in  1  transmitter currently shifting.
- tx_done  in  1  one-cycle pulse when the transmitter finishes a byte.

Behaviour:
- Reset (and DSP_clear, which has identical effect except that tx_data holds its value):
  - wr_ptr = rd_ptr = count = 0, FSM = IDLE.
  - tx_start = 0, overflow = 0, tx_data = 0.
  - Outputs after reset: DSP_status = 1, buf_empty = 1, buf_full = 0.
  - reset has priority over DSP_clear. DSP_clear has priority over every write and pop in the same cycle.
- FIFO:
  - Write accepted at an edge iff DSP_write_en && count < DEPTH, using the registered count. The {DSP_data} entry is stored at wr_ptr and wr_ptr increments.
  - Write when count == DEPTH: data is dropped, overflow is set to 1, pointers are unchanged. This holds even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH naturally. count is ADDR_W+1 bits wide.
  - Simultaneous accepted write and pop: count is unchanged, both pointers advance.
  - Flags are combinational from the registered count.
- FSM states: IDLE, WAIT.
  - IDLE, when !buf_empty && !tx_busy:
    - at the edge: tx_data <= {1'b0, mem[rd_ptr]}, rd_ptr++, count-- (pop), tx_start <= 1, go to WAIT.
  - IDLE otherwise: tx_start <= 0.
  - WAIT: tx_start <= 0 (pulse is exactly 1 cycle). Stay until tx_done = 1, then go to IDLE.
- A pop never occurs while the FIFO is empty. A write arriving while empty is first visible to the FSM at the next edge.
- Latency: write sampled at edge N, then the FSM pops at edge N+1, so tx_start is high between edges N+1 and N+2.
- Back-to-back throughput: after tx_done at edge M, the FSM returns to IDLE. The next tx_start is issued at edge M+1 if the FIFO is non-empty and tx_busy = 0.
- tx_done is ignored in IDLE.
- No timeout: if tx_done never arrives, the FSM stays in WAIT; the CPU can recover with DSP_clear.
- DSP_clear or reset during WAIT:
  - FSM returns to IDLE and no new tx_start is issued while tx_busy = 1.
  - A character already handed to the transmitter completes normally.
- tx_data holds the last sent byte until the next pop.

Optional Feature:
- Macro: DISPLAY_BUF_CRLF_EXPAND_EN.
- Defined:
  - When the head character is 0x0A and an internal crlf_pending bit = 0, IDLE sends 0x0D without popping and sets crlf_pending.
  - After that character's tx_done, the next IDLE send transmits 0x0A with a pop and clears crlf_pending.
  - crlf_pending is cleared by reset and DSP_clear.
  - One written 0x0A therefore produces two transmitted bytes.
- Undefined: every character is sent verbatim and crlf_pending does not exist.

Test Plan:
- Reset, then write 0x68 at edge N with tx_busy = 0 → tx_start is high during cycle N+1..N+2 only, tx_data = 0x68, buf_empty = 1 after edge N+1.
- Write "hello" (68 65 6C 6C 6F) on consecutive cycles; the bench model returns tx_done 10 cycles after each tx_start → bytes emerge in order, exactly 5 tx_start pulses, overflow = 0.
- Hold tx_busy = 1 and write DEPTH+2 characters → buf_full = 1 and DSP_status = 0 after DEPTH writes, overflow = 1. Release busy → exactly DEPTH bytes are sent and the first two are preserved.
- With the FIFO full, write and pop in the same cycle → write dropped, overflow = 1, count = DEPTH-1.
- Assert DSP_clear during WAIT with 3 characters queued → count = 0, overflow = 0, no further tx_start. A new write of 0x41 after tx_busy falls is sent normally.
- With DISPLAY_BUF_CRLF_EXPAND_EN defined, write 0x61, 0x0A → transmitted sequence is 0x61, 0x0D, 0x0A. Without the macro → 0x61, 0x0A.
